// File: rtl/unidade_controle.sv
// rtl/unidade_controle.sv - multi-cycle control FSM for the single-issue datapath
//
// Purpose: sequences each instruction through fetch, decode, execute, memory
// and writeback, and drives the datapath strobes for each step. It also keeps
// a retired-instruction counter and a sticky illegal-opcode flag.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   en         step enable; when 0 all state holds and write strobes are off
//   opcode     instr[6:0]; decoded in DECODIFICA, lw/sw split in ENDERECO
//   estado     current state code
//   irwrite, pcwrite, memread, memwrite, regiwrite   write/read strobes (gated by en)
//   branch, alusrc, aluop, memtoreg                  datapath selects
//   erro       sticky illegal-opcode flag
//   instr_cont retired-instruction counter (wraps)
module unidade_controle #(
  parameter int CONT_W   = 32,
  parameter bit ERR_HALT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [6:0]        opcode,
  output logic [3:0]        estado,
  output logic              irwrite,
  output logic              pcwrite,
  output logic              branch,
  output logic              alusrc,
  output logic [1:0]        aluop,
  output logic              memread,
  output logic              memwrite,
  output logic              regiwrite,
  output logic              memtoreg,
  output logic              erro,
  output logic [CONT_W-1:0] instr_cont
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef enum logic [3:0] {
    INICIO     = 4'b0000,
    BUSCA      = 4'b0001,
    DECODIFICA = 4'b0010,
    EXEC       = 4'b0011,
    ENDERECO   = 4'b0100,
    LEITURA    = 4'b0101,
    ESCR_ALU   = 4'b0110,
    ESCR_MEM   = 4'b0111,
    ARMAZENA   = 4'b1000,
    DESVIO     = 4'b1001,
    NOP        = 4'b1010,
    ERRO       = 4'b1111
  } state_t;

  state_t state;
  // I-type flag captured at decode so EXEC does not look at opcode again.
  logic   imm_q;

  assign estado = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= INICIO;
      imm_q      <= 1'b0;
      erro       <= 1'b0;
      instr_cont <= '0;
    end else if (en) begin
      case (state)
        INICIO:     state <= BUSCA;
        BUSCA:      state <= DECODIFICA;
        DECODIFICA: begin
          imm_q <= (opcode == OP_I);
          if (opcode == OP_R || opcode == OP_I) begin
            state <= EXEC;
          end else if (opcode == OP_LW || opcode == OP_SW) begin
            state <= ENDERECO;
          end else if (opcode == OP_BR) begin
            state <= DESVIO;
          end else if (ERR_HALT) begin
            state <= ERRO;
            erro  <= 1'b1;
          end else begin
            state <= NOP;
          end
        end
        EXEC:       state <= ESCR_ALU;
        ENDERECO:   state <= (opcode == OP_LW) ? LEITURA : ARMAZENA;
        LEITURA:    state <= ESCR_MEM;
        ESCR_ALU, ESCR_MEM, ARMAZENA, DESVIO, NOP: begin
          state      <= BUSCA;
          instr_cont <= instr_cont + 1'b1;
        end
        ERRO:       state <= ERRO;
        default:    state <= INICIO;
      endcase
    end
  end

  // Moore decode of the registered state; write/read strobes are gated by en
  // so a held state never repeats a write.
  always_comb begin
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    branch    = 1'b0;
    alusrc    = 1'b0;
    aluop     = 2'b00;
    memread   = 1'b0;
    memwrite  = 1'b0;
    regiwrite = 1'b0;
    memtoreg  = 1'b0;
    case (state)
      BUSCA:    irwrite = en;
      EXEC: begin
        aluop  = 2'b10;
        alusrc = imm_q;
      end
      ENDERECO: alusrc = 1'b1;
      LEITURA: begin
        memread = en;
        alusrc  = 1'b1;
      end
      ESCR_ALU: begin
        regiwrite = en;
        pcwrite   = en;
      end
      ESCR_MEM: begin
        regiwrite = en;
        memtoreg  = 1'b1;
        memread   = en;
        pcwrite   = en;
      end
      ARMAZENA: begin
        memwrite = en;
        alusrc   = 1'b1;
        pcwrite  = en;
      end
      DESVIO: begin
        aluop   = 2'b01;
        branch  = 1'b1;
        pcwrite = en;
      end
      NOP:      pcwrite = en;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle.sv
// tb/tb_unidade_controle.sv - directed self-checking bench for unidade_controle
module tb_unidade_controle;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [6:0] opcode = 7'b0;

  // dut: ERR_HALT=1, CONT_W=4; dut0: ERR_HALT=0, CONT_W=2 (for wrap)
  logic [3:0] a_estado, b_estado;
  logic       a_irwrite, a_pcwrite, a_branch, a_alusrc, a_memread, a_memwrite, a_regiwrite, a_memtoreg, a_erro;
  logic       b_irwrite, b_pcwrite, b_branch, b_alusrc, b_memread, b_memwrite, b_regiwrite, b_memtoreg, b_erro;
  logic [1:0] a_aluop, b_aluop;
  logic [3:0] a_cont;
  logic [1:0] b_cont;

  int checks = 0;
  int failures = 0;

  unidade_controle #(.CONT_W(4), .ERR_HALT(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .estado(a_estado),
    .irwrite(a_irwrite), .pcwrite(a_pcwrite), .branch(a_branch), .alusrc(a_alusrc),
    .aluop(a_aluop), .memread(a_memread), .memwrite(a_memwrite), .regiwrite(a_regiwrite),
    .memtoreg(a_memtoreg), .erro(a_erro), .instr_cont(a_cont)
  );

  unidade_controle #(.CONT_W(2), .ERR_HALT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .estado(b_estado),
    .irwrite(b_irwrite), .pcwrite(b_pcwrite), .branch(b_branch), .alusrc(b_alusrc),
    .aluop(b_aluop), .memread(b_memread), .memwrite(b_memwrite), .regiwrite(b_regiwrite),
    .memtoreg(b_memtoreg), .erro(b_erro), .instr_cont(b_cont)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    en  = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] strobes;
    en  = 1'b1;
    rst = 1'b0;
    tick();
    strobes = {a_irwrite, a_pcwrite, a_branch, a_alusrc, a_aluop, a_memread, a_memwrite, a_regiwrite, a_memtoreg};
    checks++;
    if (a_estado !== 4'b0000) begin failures++; $display("FAIL reset_estado got=%b exp=0000", a_estado); end
    checks++;
    if (strobes !== 10'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=0", strobes); end
    checks++;
    if (a_erro !== 1'b0 || a_cont !== 4'd0) begin failures++; $display("FAIL reset_erro_cont got=%b/%0d exp=0/0", a_erro, a_cont); end
    rst = 1'b1;
    #1;
  endtask

  // From INICIO with R-type: 0001,0010,0011,0110,0001
  task automatic test_r_type();
    logic [3:0] exp_s [5] = '{4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b0001};
    opcode = 7'b0110011;
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (a_estado !== exp_s[i]) begin failures++; $display("FAIL r_estado[%0d] got=%b exp=%b", i, a_estado, exp_s[i]); end
      checks++;
      if (a_regiwrite !== (exp_s[i] == 4'b0110)) begin failures++; $display("FAIL r_regiwrite[%0d] got=%b exp=%b", i, a_regiwrite, exp_s[i] == 4'b0110); end
      if (exp_s[i] == 4'b0001) begin
        checks++;
        if (a_irwrite !== 1'b1) begin failures++; $display("FAIL r_irwrite got=%b exp=1", a_irwrite); end
      end
      if (exp_s[i] == 4'b0011) begin
        checks++;
        if (a_aluop !== 2'b10 || a_alusrc !== 1'b0) begin failures++; $display("FAIL r_exec_sel got=%b/%b exp=10/0", a_aluop, a_alusrc); end
      end
    end
    checks++;
    if (a_cont !== 4'd1) begin failures++; $display("FAIL r_cont got=%0d exp=1", a_cont); end
  endtask

  // From BUSCA with lw: 0010,0100,0101,0111,0001 (5 cycles)
  task automatic test_lw();
    logic [3:0] exp_s [5] = '{4'b0010, 4'b0100, 4'b0101, 4'b0111, 4'b0001};
    opcode = 7'b0000011;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (a_estado !== exp_s[i]) begin failures++; $display("FAIL lw_estado[%0d] got=%b exp=%b", i, a_estado, exp_s[i]); end
      if (exp_s[i] == 4'b0101) begin
        checks++;
        if (a_memread !== 1'b1 || a_regiwrite !== 1'b0) begin failures++; $display("FAIL lw_read got=%b/%b exp=1/0", a_memread, a_regiwrite); end
      end
      if (exp_s[i] == 4'b0111) begin
        checks++;
        if (a_memtoreg !== 1'b1 || a_regiwrite !== 1'b1 || a_pcwrite !== 1'b1) begin
          failures++; $display("FAIL lw_wb got=%b%b%b exp=111", a_memtoreg, a_regiwrite, a_pcwrite);
        end
      end
    end
    checks++;
    if (a_cont !== 4'd2) begin failures++; $display("FAIL lw_cont got=%0d exp=2", a_cont); end
  endtask

  // From BUSCA with sw: 0010,0100,1000,0001
  task automatic test_sw();
    logic [3:0] exp_s [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int rw_seen = 0;
    opcode = 7'b0100011;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (a_regiwrite === 1'b1) rw_seen++;
      checks++;
      if (a_estado !== exp_s[i]) begin failures++; $display("FAIL sw_estado[%0d] got=%b exp=%b", i, a_estado, exp_s[i]); end
      if (exp_s[i] == 4'b1000) begin
        checks++;
        if (a_memwrite !== 1'b1 || a_alusrc !== 1'b1) begin failures++; $display("FAIL sw_write got=%b/%b exp=1/1", a_memwrite, a_alusrc); end
      end
    end
    checks++;
    if (rw_seen !== 0) begin failures++; $display("FAIL sw_regiwrite got=%0d exp=0", rw_seen); end
    checks++;
    if (a_cont !== 4'd3) begin failures++; $display("FAIL sw_cont got=%0d exp=3", a_cont); end
  endtask

  // From BUSCA with branch: 0010,1001,0001
  task automatic test_branch();
    opcode = 7'b1100011;
    tick();
    tick();
    checks++;
    if (a_estado !== 4'b1001 || a_branch !== 1'b1 || a_aluop !== 2'b01 || a_pcwrite !== 1'b1) begin
      failures++; $display("FAIL br_desvio got=%b b=%b op=%b pc=%b exp=1001 1 01 1", a_estado, a_branch, a_aluop, a_pcwrite);
    end
    tick();
    checks++;
    if (a_estado !== 4'b0001 || a_cont !== 4'd4) begin failures++; $display("FAIL br_retire got=%b/%0d exp=0001/4", a_estado, a_cont); end
  endtask

  task automatic test_hold();
    int writes = 0;
    opcode = 7'b0110011;
    tick(); tick(); tick();
    checks++;
    if (a_estado !== 4'b0110) begin failures++; $display("FAIL hold_enter got=%b exp=0110", a_estado); end
    en = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (a_estado !== 4'b0110 || a_regiwrite !== 1'b0 || a_pcwrite !== 1'b0) begin
        failures++; $display("FAIL hold[%0d] got=%b rw=%b pc=%b exp=0110 0 0", i, a_estado, a_regiwrite, a_pcwrite);
      end
    end
    checks++;
    if (a_cont !== 4'd4) begin failures++; $display("FAIL hold_cont got=%0d exp=4", a_cont); end
    en = 1'b1;
    #1;
    if (a_regiwrite === 1'b1) writes++;
    tick();
    if (a_regiwrite === 1'b1) writes++;
    checks++;
    if (writes !== 1) begin failures++; $display("FAIL hold_one_write got=%0d exp=1", writes); end
    checks++;
    if (a_estado !== 4'b0001 || a_cont !== 4'd5) begin failures++; $display("FAIL hold_resume got=%b/%0d exp=0001/5", a_estado, a_cont); end
  endtask

  task automatic test_error();
    apply_reset();
    en = 1'b1;
    opcode = 7'b1111111;
    tick(); tick(); tick();
    checks++;
    if (a_estado !== 4'b1111 || a_erro !== 1'b1) begin failures++; $display("FAIL err_enter got=%b/%b exp=1111/1", a_estado, a_erro); end
    checks++;
    if (b_estado !== 4'b1010 || b_pcwrite !== 1'b1 || b_erro !== 1'b0) begin
      failures++; $display("FAIL nop_enter got=%b pc=%b err=%b exp=1010 1 0", b_estado, b_pcwrite, b_erro);
    end
    opcode = 7'b0110011;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (a_estado !== 4'b1111 || a_erro !== 1'b1 ||
          {a_irwrite, a_pcwrite, a_memread, a_memwrite, a_regiwrite} !== 5'b0) begin
        failures++; $display("FAIL err_hold[%0d] got=%b err=%b", i, a_estado, a_erro);
      end
      if (i == 0) begin
        checks++;
        if (b_estado !== 4'b0001 || b_cont !== 2'd1) begin failures++; $display("FAIL nop_retire got=%b/%0d exp=0001/1", b_estado, b_cont); end
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (a_estado !== 4'b0000 || a_erro !== 1'b0) begin failures++; $display("FAIL err_clear got=%b/%b exp=0000/0", a_estado, a_erro); end
    rst = 1'b1;
    #1;
  endtask

  task automatic test_async_reset();
    apply_reset();
    en = 1'b1;
    opcode = 7'b0000011;
    tick(); tick(); tick(); tick();
    checks++;
    if (a_estado !== 4'b0101 || a_memread !== 1'b1) begin failures++; $display("FAIL ar_pre got=%b/%b exp=0101/1", a_estado, a_memread); end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (a_estado !== 4'b0000 || a_memread !== 1'b0) begin failures++; $display("FAIL ar_async got=%b/%b exp=0000/0", a_estado, a_memread); end
    #1 rst = 1'b1;
    tick();
    checks++;
    if (a_estado !== 4'b0001 || a_cont !== 4'd0) begin failures++; $display("FAIL ar_restart got=%b/%0d exp=0001/0", a_estado, a_cont); end
  endtask

  // CONT_W=2 copy: four retires wrap 3 -> 0
  task automatic test_wrap();
    apply_reset();
    en = 1'b1;
    opcode = 7'b0010011;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick(); tick();
      if (k == 0) begin
        checks++;
        if (a_alusrc !== 1'b1 || a_aluop !== 2'b10) begin failures++; $display("FAIL i_exec got=%b/%b exp=1/10", a_alusrc, a_aluop); end
      end
      tick(); tick();
      checks++;
      if (b_cont !== 2'((k + 1) % 4) || a_cont !== 4'(k + 1)) begin
        failures++; $display("FAIL wrap[%0d] got=%0d/%0d exp=%0d/%0d", k, b_cont, a_cont, (k + 1) % 4, k + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_lw();
    test_sw();
    test_branch();
    test_hold();
    test_error();
    test_async_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
